// File: rtl/arf124b256e1r1w0cbbehcaa4acw_pkg.sv
// arf124b256e1r1w0cbbehcaa4acw_pkg: shared geometry and types for the 256x124 1R1W register-file port controller.
package arf124b256e1r1w0cbbehcaa4acw_pkg;
  localparam int ARF_DW = 124;
  localparam int ARF_AW = 8;
  localparam int ARF_DEPTH = 256;
  typedef enum logic {INIT, RUN} state_t;
  typedef logic [ARF_AW-1:0] adr_t;
  typedef logic [ARF_DW-1:0] dat_t;
endpackage

// File: rtl/arf124b256e1r1w0cbbehcaa4acw_clk_and.sv
// arf124b256e1r1w0cbbehcaa4acw_clk_and: map-layer clock-gate cell; enable is latched while clk is low.
module arf124b256e1r1w0cbbehcaa4acw_clk_and (
  input  logic clk,
  input  logic en,
  output logic gclk
);
  logic en_l;
  always_latch if (!clk) en_l = en;
  assign gclk = clk & en_l;
endmodule

// File: rtl/arf124b256e1r1w0cbbehcaa4acw_port_ctl.sv
// arf124b256e1r1w0cbbehcaa4acw_port_ctl: write staging, clear sweep and read issue for the 256x124 1R1W array.
// Define ARF124B256E1R1W0CBBEHCAA4ACW_RAW_BYPASS_EN to forward in-flight write data to colliding reads.
module arf124b256e1r1w0cbbehcaa4acw_port_ctl
  import arf124b256e1r1w0cbbehcaa4acw_pkg::*;
#(
  parameter int DW = ARF_DW,
  parameter int AW = ARF_AW,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          wr_vld,
  output logic          wr_rdy,
  input  logic [AW-1:0] wr_adr,
  input  logic [DW-1:0] wr_dat,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_adr,
  output logic          rd_vld,
  output logic [DW-1:0] rd_dat,
  input  logic          init_req,
  output logic          init_done,
  output logic          arr_wen,
  output logic [AW-1:0] arr_wadr,
  output logic [DW-1:0] arr_wdat,
  output logic          arr_wclk,
  output logic          arr_ren,
  output logic [AW-1:0] arr_radr,
  input  logic [DW-1:0] arr_rdat
);
  state_t state, state_nx;
  logic [AW-1:0] cnt, cnt_nx, wadr_nx;
  logic [DW-1:0] wdat_nx;
  logic last, last_nx, wen_nx, run, wr_acc;
  assign run = state == RUN;
  assign wr_rdy = run;
  assign init_done = run;
  assign wr_acc = wr_vld & run;
  assign arr_ren = rd_en & run;
  assign arr_radr = run ? rd_adr : '0;
  // last marks the cycle after entry 255 was issued; the FSM leaves INIT only then
  always_comb begin
    state_nx = run ? (init_req ? INIT : RUN) : (last ? RUN : INIT);
    cnt_nx = run ? (init_req ? '0 : cnt) : (last ? cnt : cnt + 1'b1);
    last_nx = !run && !last && cnt == '1;
    wen_nx = run ? wr_acc : !last;
    wadr_nx = run ? (wr_acc ? wr_adr : arr_wadr) : cnt;
    wdat_nx = run ? (wr_acc ? wr_dat : arr_wdat) : INIT_VAL;
  end
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= INIT;
      cnt <= '0;
      last <= 1'b0;
      arr_wen <= 1'b0;
      arr_wadr <= '0;
      arr_wdat <= '0;
      rd_vld <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      last <= last_nx;
      arr_wen <= wen_nx;
      arr_wadr <= wadr_nx;
      arr_wdat <= wdat_nx;
      rd_vld <= arr_ren;
    end
  end
`ifdef ARF124B256E1R1W0CBBEHCAA4ACW_RAW_BYPASS_EN
  logic byp;
  logic [DW-1:0] byp_dat;
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      byp <= 1'b0;
      byp_dat <= '0;
    end else begin
      byp <= arr_ren & arr_wen & (rd_adr == arr_wadr);
      if (arr_ren & arr_wen & (rd_adr == arr_wadr)) byp_dat <= arr_wdat;
    end
  end
  assign rd_dat = !rd_vld ? '0 : byp ? byp_dat : arr_rdat;
`else
  assign rd_dat = rd_vld ? arr_rdat : '0;
`endif
  arf124b256e1r1w0cbbehcaa4acw_clk_and u_cg (
    .clk (clk),
    .en  (arr_wen),
    .gclk(arr_wclk)
  );
endmodule

// File: tb/tb_arf124b256e1r1w0cbbehcaa4acw_port_ctl.sv
// tb_arf124b256e1r1w0cbbehcaa4acw_port_ctl: randomized bench with an array model and a write-visibility reference model.
module tb_arf124b256e1r1w0cbbehcaa4acw_port_ctl;
  import arf124b256e1r1w0cbbehcaa4acw_pkg::*;
`ifdef ARF124B256E1R1W0CBBEHCAA4ACW_RAW_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0, rstb = 1'b0, wr_vld = 1'b0, rd_en = 1'b0, init_req = 1'b0;
  adr_t wr_adr = '0, rd_adr = '0, arr_wadr, arr_radr;
  dat_t wr_dat = '0, rd_dat, arr_wdat, arr_rdat = '0;
  logic wr_rdy, rd_vld, init_done, arr_wen, arr_wclk, arr_ren;
  int total = 0, bad = 0;
  dat_t mem [ARF_DEPTH];
  dat_t ref_mem [ARF_DEPTH];
  logic lw_v;
  adr_t lw_a;
  dat_t lw_d;
  always #5 clk = ~clk;
  arf124b256e1r1w0cbbehcaa4acw_port_ctl dut (
    .clk(clk), .rstb(rstb), .wr_vld(wr_vld), .wr_rdy(wr_rdy), .wr_adr(wr_adr), .wr_dat(wr_dat),
    .rd_en(rd_en), .rd_adr(rd_adr), .rd_vld(rd_vld), .rd_dat(rd_dat), .init_req(init_req),
    .init_done(init_done), .arr_wen(arr_wen), .arr_wadr(arr_wadr), .arr_wdat(arr_wdat),
    .arr_wclk(arr_wclk), .arr_ren(arr_ren), .arr_radr(arr_radr), .arr_rdat(arr_rdat)
  );
  // array: written on the gated clock, registered read-before-write
  always @(posedge arr_wclk) mem[arr_wadr] <= arr_wdat;
  always @(posedge clk) if (arr_ren) arr_rdat <= mem[arr_radr];
  task chk(input string tag, input dat_t got, input dat_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic dat_t rnd_dat();
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    return t[ARF_DW-1:0];
  endfunction
  task model_clear();
    for (int i = 0; i < ARF_DEPTH; i++) ref_mem[i] = '0;
    lw_v = 1'b0;
  endtask
  task chk_rst();
    chk("rst_wr_rdy", dat_t'(wr_rdy), '0);
    chk("rst_rd_vld", dat_t'(rd_vld), '0);
    chk("rst_rd_dat", rd_dat, '0);
    chk("rst_init_done", dat_t'(init_done), '0);
    chk("rst_arr_wen", dat_t'(arr_wen), '0);
    chk("rst_arr_wadr", dat_t'(arr_wadr), '0);
    chk("rst_arr_wdat", arr_wdat, '0);
    chk("rst_arr_ren", dat_t'(arr_ren), '0);
    chk("rst_arr_radr", dat_t'(arr_radr), '0);
  endtask
  // a read issued in cycle M sees writes accepted before M-1, or before M when bypassing
  task cyc(input logic wv, input adr_t wa, input dat_t wd, input logic re, input adr_t ra);
    dat_t exp;
    wr_vld = wv; wr_adr = wa; wr_dat = wd; rd_en = re; rd_adr = ra;
    exp = (BYP && lw_v && lw_a == ra) ? lw_d : ref_mem[ra];
    if (wv) chk("wr_rdy", dat_t'(wr_rdy), dat_t'(1));
    @(posedge clk); #1;
    chk("rd_vld", dat_t'(rd_vld), dat_t'(re));
    if (re) chk("rd_dat", rd_dat, exp);
    if (lw_v) ref_mem[lw_a] = lw_d;
    lw_v = wv; lw_a = wa; lw_d = wd;
    wr_vld = 1'b0; rd_en = 1'b0; init_req = 1'b0;
  endtask
  // next edge must issue sweep entry 0; reads and a stray init_req are driven throughout
  task sweep(input bit poke);
    int good;
    good = 0;
    for (int k = 0; k < ARF_DEPTH; k++) begin
      rd_en = 1'b1; rd_adr = adr_t'(k); init_req = poke && k == 50;
      @(posedge clk); #1;
      if (arr_wen === 1'b1 && arr_wadr === adr_t'(k) && arr_wdat === '0 && wr_rdy === 1'b0 &&
          init_done === 1'b0 && rd_vld === 1'b0 && arr_ren === 1'b0) good++;
    end
    rd_en = 1'b0; init_req = 1'b0;
    chk("sweep_cycles", dat_t'(good), dat_t'(256));
    @(posedge clk); #1;
    chk("sweep_init_done", dat_t'(init_done), dat_t'(1));
    chk("sweep_end_wen", dat_t'(arr_wen), '0);
    model_clear();
  endtask
  initial begin
    for (int i = 0; i < ARF_DEPTH; i++) mem[i] = rnd_dat();
    model_clear();
    #2 chk_rst();
    @(negedge clk); @(negedge clk);
    chk("rst_wclk", dat_t'(arr_wclk), '0);
    rstb = 1'b1;
    sweep(1'b1);
    cyc(1'b1, 8'h12, 124'hA5A5, 1'b0, '0);
    repeat (3) cyc(1'b0, '0, '0, 1'b0, '0);
    cyc(1'b0, '0, '0, 1'b1, 8'h12);
    chk("rd_12", rd_dat, 124'hA5A5);
    cyc(1'b1, 8'h40, 124'h1, 1'b0, '0);
    cyc(1'b0, '0, '0, 1'b1, 8'h40);
    chk("rd_40_raw", rd_dat, BYP ? 124'h1 : 124'h0);
    cyc(1'b1, 8'h7F, 124'h3, 1'b0, '0);
    repeat (2) cyc(1'b0, '0, '0, 1'b0, '0);
    cyc(1'b1, 8'h7F, 124'h9, 1'b1, 8'h7F);
    chk("rd_7f_same", rd_dat, 124'h3);
    repeat (2) cyc(1'b0, '0, '0, 1'b0, '0);
    cyc(1'b0, '0, '0, 1'b1, 8'h7F);
    chk("rd_7f_new", rd_dat, 124'h9);
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 1)), adr_t'($urandom_range(0, 15)), rnd_dat(),
          1'($urandom_range(0, 1)), adr_t'($urandom_range(0, 15)));
    init_req = 1'b1;
    cyc(1'b1, 8'h05, 124'hF, 1'b0, '0);
    chk("ir_wen", dat_t'(arr_wen), dat_t'(1));
    chk("ir_wadr", dat_t'(arr_wadr), dat_t'(8'h05));
    chk("ir_wdat", arr_wdat, 124'hF);
    chk("ir_wr_rdy", dat_t'(wr_rdy), '0);
    sweep(1'b1);
    cyc(1'b0, '0, '0, 1'b1, 8'h05);
    chk("rd_05_cleared", rd_dat, '0);
    for (int i = 0; i < 100; i++)
      cyc(1'($urandom_range(0, 1)), adr_t'($urandom_range(0, 255)), rnd_dat(),
          1'($urandom_range(0, 1)), adr_t'($urandom_range(0, 255)));
    init_req = 1'b1;
    cyc(1'b0, '0, '0, 1'b0, '0);
    repeat (100) @(posedge clk);
    #3 rstb = 1'b0;
    #1 chk_rst();
    @(negedge clk); @(negedge clk);
    chk("rst2_wclk", dat_t'(arr_wclk), '0);
    rstb = 1'b1;
    sweep(1'b0);
    for (int i = 0; i < 50; i++)
      cyc(1'b0, '0, '0, 1'b1, adr_t'($urandom_range(0, 255)));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
